// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the dual-issue decode controller: FSM encoding,
// branch-forward select codes and register-zero helpers.
package dual_issue_scheduler_pkg;

  typedef enum logic {
    PAIR  = 1'b0,
    SLOT1 = 1'b1
  } issue_state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_M0 = 2'b01;
  localparam fwd_sel_t FWD_M1 = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Decode-side bundle for the scheduler: pair description, E/M hazard info in,
// issue/stall/forward controls and performance counters out.
interface dual_issue_scheduler_if #(parameter int CNT_W = 32);
  logic       valid_d, redirect_d;
  logic [4:0] rs_d_0, rt_d_0, dst_d_0, rs_d_1, rt_d_1, dst_d_1;
  logic       regwrite_d_0, memop_d_0, ctrl_d_0;
  logic       regwrite_d_1, memop_d_1, ctrl_d_1;
  logic [4:0] dst_e_0, dst_e_1;
  logic       memread_e_0, regwrite_e_0, memread_e_1, regwrite_e_1;
  logic [4:0] writeReg_m_0, writeReg_m_1;
  logic       regWrite_m_0, regWrite_m_1;

  logic       issue_0, issue_1, stall_d, bubble_e;
  logic [1:0] forwarda_d_0, forwardb_d_0, forwarda_d_1, forwardb_d_1;
  logic [CNT_W-1:0] cnt_pair, cnt_split, cnt_stall;

  // Control is purely combinational in the decode cycle; there is no
  // valid/ready handshake -- stall_d is the only back-pressure to fetch/decode.
  modport master (
    output valid_d, redirect_d, rs_d_0, rt_d_0, dst_d_0, rs_d_1, rt_d_1, dst_d_1,
           regwrite_d_0, memop_d_0, ctrl_d_0, regwrite_d_1, memop_d_1, ctrl_d_1,
           dst_e_0, dst_e_1, memread_e_0, regwrite_e_0, memread_e_1, regwrite_e_1,
           writeReg_m_0, writeReg_m_1, regWrite_m_0, regWrite_m_1,
    input  issue_0, issue_1, stall_d, bubble_e,
           forwarda_d_0, forwardb_d_0, forwarda_d_1, forwardb_d_1,
           cnt_pair, cnt_split, cnt_stall
  );

  modport slave (
    input  valid_d, redirect_d, rs_d_0, rt_d_0, dst_d_0, rs_d_1, rt_d_1, dst_d_1,
           regwrite_d_0, memop_d_0, ctrl_d_0, regwrite_d_1, memop_d_1, ctrl_d_1,
           dst_e_0, dst_e_1, memread_e_0, regwrite_e_0, memread_e_1, regwrite_e_1,
           writeReg_m_0, writeReg_m_1, regWrite_m_0, regWrite_m_1,
    output issue_0, issue_1, stall_d, bubble_e,
           forwarda_d_0, forwardb_d_0, forwarda_d_1, forwardb_d_1,
           cnt_pair, cnt_split, cnt_stall
  );
endinterface

// File: rtl/dual_issue_scheduler_fwd_sel.sv
// Branch-compare operand select for one decode source register.
module branch_fwd_sel
  import dual_issue_scheduler_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] wreg_m0_i,
  input  logic       wen_m0_i,
  input  logic [4:0] wreg_m1_i,
  input  logic       wen_m1_i,
  output fwd_sel_t   sel_o
);
  // M1 is checked first: slot 1 is younger, so its value is the newest.
  always_comb begin
    sel_o = FWD_RF;
    if (wen_m1_i && reg_match(src_i, wreg_m1_i))      sel_o = FWD_M1;
    else if (wen_m0_i && reg_match(src_i, wreg_m0_i)) sel_o = FWD_M0;
  end
endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-wide issue controller: pair/split/stall decision, branch forward selects
// and saturating issue performance counters.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  dual_issue_scheduler_if.slave dif,
  output issue_state_e state_o
);
  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_pair_q, cnt_pair_d, cnt_split_q, cnt_split_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic             lu_0, lu_1, split_pair;
  logic             issue_0, issue_1, stall_d, bubble_e;

  function automatic logic load_use(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] de, input logic mr, input logic rw);
    return mr && rw && (reg_match(rs, de) || reg_match(rt, de));
  endfunction

  assign lu_0 = load_use(dif.rs_d_0, dif.rt_d_0, dif.dst_e_0, dif.memread_e_0, dif.regwrite_e_0)
             || load_use(dif.rs_d_0, dif.rt_d_0, dif.dst_e_1, dif.memread_e_1, dif.regwrite_e_1);
  assign lu_1 = load_use(dif.rs_d_1, dif.rt_d_1, dif.dst_e_0, dif.memread_e_0, dif.regwrite_e_0)
             || load_use(dif.rs_d_1, dif.rt_d_1, dif.dst_e_1, dif.memread_e_1, dif.regwrite_e_1);

  // A branch in slot 0 is deliberately absent: its delay slot pairs with it.
  assign split_pair =
      (dif.regwrite_d_0 && (reg_match(dif.rs_d_1, dif.dst_d_0) || reg_match(dif.rt_d_1, dif.dst_d_0)))
   || (dif.regwrite_d_0 && dif.regwrite_d_1 && reg_match(dif.dst_d_0, dif.dst_d_1))
   || (dif.memop_d_0 && dif.memop_d_1)
   || dif.ctrl_d_1;

  always_comb begin
    state_d  = state_q;
    issue_0  = 1'b0;
    issue_1  = 1'b0;
    stall_d  = 1'b0;
    bubble_e = 1'b0;
    case (state_q)
      PAIR: begin
        if (dif.redirect_d) begin
          issue_0 = 1'b1;
          issue_1 = 1'b1;
        end else if (!dif.valid_d) begin
          state_d = PAIR;
        end else if (lu_0) begin
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end else if (!split_pair && !lu_1) begin
          issue_0 = 1'b1;
          issue_1 = 1'b1;
        end else begin
          issue_0 = 1'b1;
          stall_d = 1'b1;
          state_d = SLOT1;
        end
      end
      SLOT1: begin
        if (!dif.redirect_d && lu_1) begin
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end else begin
          issue_1 = 1'b1;
          state_d = PAIR;
        end
      end
    endcase
  end

  always_comb begin
    cnt_pair_d  = cnt_pair_q;
    cnt_split_d = cnt_split_q;
    cnt_stall_d = cnt_stall_q;
    if (issue_0 && issue_1 && cnt_pair_q != '1)                    cnt_pair_d  = cnt_pair_q + 1'b1;
    if (state_q == PAIR && state_d == SLOT1 && cnt_split_q != '1) cnt_split_d = cnt_split_q + 1'b1;
    if (bubble_e && cnt_stall_q != '1)                             cnt_stall_d = cnt_stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PAIR;
      cnt_pair_q  <= '0;
      cnt_split_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_pair_q  <= cnt_pair_d;
      cnt_split_q <= cnt_split_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  branch_fwd_sel u_fa0 (.src_i(dif.rs_d_0), .wreg_m0_i(dif.writeReg_m_0), .wen_m0_i(dif.regWrite_m_0),
                        .wreg_m1_i(dif.writeReg_m_1), .wen_m1_i(dif.regWrite_m_1), .sel_o(dif.forwarda_d_0));
  branch_fwd_sel u_fb0 (.src_i(dif.rt_d_0), .wreg_m0_i(dif.writeReg_m_0), .wen_m0_i(dif.regWrite_m_0),
                        .wreg_m1_i(dif.writeReg_m_1), .wen_m1_i(dif.regWrite_m_1), .sel_o(dif.forwardb_d_0));
  branch_fwd_sel u_fa1 (.src_i(dif.rs_d_1), .wreg_m0_i(dif.writeReg_m_0), .wen_m0_i(dif.regWrite_m_0),
                        .wreg_m1_i(dif.writeReg_m_1), .wen_m1_i(dif.regWrite_m_1), .sel_o(dif.forwarda_d_1));
  branch_fwd_sel u_fb1 (.src_i(dif.rt_d_1), .wreg_m0_i(dif.writeReg_m_0), .wen_m0_i(dif.regWrite_m_0),
                        .wreg_m1_i(dif.writeReg_m_1), .wen_m1_i(dif.regWrite_m_1), .sel_o(dif.forwardb_d_1));

  assign dif.issue_0   = issue_0;
  assign dif.issue_1   = issue_1;
  assign dif.stall_d   = stall_d;
  assign dif.bubble_e  = bubble_e;
  assign dif.cnt_pair  = cnt_pair_q;
  assign dif.cnt_split = cnt_split_q;
  assign dif.cnt_stall = cnt_stall_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed and randomized checks of dual_issue_scheduler against a small
// instruction-level model of the issue rules.
module tb_dual_issue_scheduler;
  import dual_issue_scheduler_pkg::*;

  logic         clk;
  logic         reset;
  issue_state_e state_o;
  int           total = 0;
  int           bad   = 0;

  dual_issue_scheduler_if #(.CNT_W(32)) dif ();
  dual_issue_scheduler #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .dif(dif), .state_o(state_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: is slot 1 of the current pair still waiting to issue?
  bit          m_pending;
  logic [31:0] m_pair, m_split, m_stall;
  bit          e_i0, e_i1, e_st, e_bb, e_pending_next;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dep(input logic [4:0] r, input logic [4:0] d);
    return (r != 5'd0) && (r == d);
  endfunction

  function automatic bit reads(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d);
    return dep(rs, d) || dep(rt, d);
  endfunction

  function automatic bit waits_on_load(input logic [4:0] rs, input logic [4:0] rt);
    return (dif.memread_e_0 && dif.regwrite_e_0 && reads(rs, rt, dif.dst_e_0))
        || (dif.memread_e_1 && dif.regwrite_e_1 && reads(rs, rt, dif.dst_e_1));
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] s);
    if (dif.regWrite_m_1 && dep(s, dif.writeReg_m_1)) return 2'd2;
    if (dif.regWrite_m_0 && dep(s, dif.writeReg_m_0)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_eval();
    bit hold0, hold1, must_split;
    hold0 = waits_on_load(dif.rs_d_0, dif.rt_d_0);
    hold1 = waits_on_load(dif.rs_d_1, dif.rt_d_1);
    must_split = (dif.regwrite_d_0 && reads(dif.rs_d_1, dif.rt_d_1, dif.dst_d_0))
              || (dif.regwrite_d_0 && dif.regwrite_d_1 && dep(dif.dst_d_0, dif.dst_d_1))
              || (dif.memop_d_0 && dif.memop_d_1) || dif.ctrl_d_1 || hold1;
    {e_i0, e_i1, e_st, e_bb} = 4'b0000;
    e_pending_next = 1'b0;
    if (!m_pending) begin
      if (dif.redirect_d)     {e_i0, e_i1} = 2'b11;
      else if (!dif.valid_d)  e_i0 = 1'b0;
      else if (hold0)         {e_st, e_bb} = 2'b11;
      else if (!must_split)   {e_i0, e_i1} = 2'b11;
      else begin
        {e_i0, e_st} = 2'b11;
        e_pending_next = 1'b1;
      end
    end else begin
      if (!dif.redirect_d && hold1) begin
        {e_st, e_bb} = 2'b11;
        e_pending_next = 1'b1;
      end else e_i1 = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    model_eval();
    check({tag, ".issue_0"},  32'(dif.issue_0),  32'(e_i0));
    check({tag, ".issue_1"},  32'(dif.issue_1),  32'(e_i1));
    check({tag, ".stall_d"},  32'(dif.stall_d),  32'(e_st));
    check({tag, ".bubble_e"}, 32'(dif.bubble_e), 32'(e_bb));
    check({tag, ".fa0"}, 32'(dif.forwarda_d_0), 32'(fwd(dif.rs_d_0)));
    check({tag, ".fb0"}, 32'(dif.forwardb_d_0), 32'(fwd(dif.rt_d_0)));
    check({tag, ".fa1"}, 32'(dif.forwarda_d_1), 32'(fwd(dif.rs_d_1)));
    check({tag, ".fb1"}, 32'(dif.forwardb_d_1), 32'(fwd(dif.rt_d_1)));
    check({tag, ".cnt_pair"},  dif.cnt_pair,  m_pair);
    check({tag, ".cnt_split"}, dif.cnt_split, m_split);
    check({tag, ".cnt_stall"}, dif.cnt_stall, m_stall);
    check({tag, ".state"}, 32'(state_o), 32'(m_pending));
    check({tag, ".i0_bb_excl"}, 32'(dif.issue_0 & dif.bubble_e), 32'd0);
  endtask

  task automatic clear_inputs();
    {dif.valid_d, dif.redirect_d} = '0;
    {dif.rs_d_0, dif.rt_d_0, dif.dst_d_0, dif.rs_d_1, dif.rt_d_1, dif.dst_d_1} = '0;
    {dif.regwrite_d_0, dif.memop_d_0, dif.ctrl_d_0, dif.regwrite_d_1, dif.memop_d_1, dif.ctrl_d_1} = '0;
    {dif.dst_e_0, dif.dst_e_1, dif.memread_e_0, dif.regwrite_e_0, dif.memread_e_1, dif.regwrite_e_1} = '0;
    {dif.writeReg_m_0, dif.writeReg_m_1, dif.regWrite_m_0, dif.regWrite_m_1} = '0;
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_pair = '0;
    m_split = '0;
    m_stall = '0;
  endtask

  // Check the current decode cycle, then advance model and DUT one clock.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (e_i0 && e_i1 && m_pair != '1) m_pair++;
    if (!m_pending && e_pending_next && m_split != '1) m_split++;
    if (e_bb && m_stall != '1) m_stall++;
    m_pending = e_pending_next;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Independent pair.
    dif.valid_d = 1'b1;
    dif.dst_d_0 = 5'd16; dif.regwrite_d_0 = 1'b1;
    dif.dst_d_1 = 5'd17; dif.regwrite_d_1 = 1'b1;
    step("indep");
    check("indep.cnt_pair_is_1", dif.cnt_pair, 32'd1);

    // RAW inside the pair: two cycles.
    dif.rs_d_1 = 5'd16;
    step("raw.c1");
    step("raw.c2");
    check("raw.cnt_split_is_1", dif.cnt_split, 32'd1);

    // Load-use on slot 0: one bubble, then the pair issues.
    clear_inputs();
    dif.valid_d = 1'b1;
    dif.dst_e_0 = 5'd8; dif.memread_e_0 = 1'b1; dif.regwrite_e_0 = 1'b1;
    dif.rs_d_0 = 5'd8;
    step("loaduse.c1");
    {dif.dst_e_0, dif.memread_e_0, dif.regwrite_e_0} = '0;
    step("loaduse.c2");
    check("loaduse.cnt_stall_is_1", dif.cnt_stall, 32'd1);

    // Forwarding priority and the $0 exemption.
    clear_inputs();
    dif.writeReg_m_0 = 5'd5; dif.writeReg_m_1 = 5'd5;
    dif.regWrite_m_0 = 1'b1; dif.regWrite_m_1 = 1'b1;
    dif.rs_d_0 = 5'd5;
    #1;
    check("fwd.both_m_gives_10", 32'(dif.forwarda_d_0), 32'd2);
    step("fwd.a");
    dif.rs_d_0 = 5'd0;
    #1;
    check("fwd.zero_gives_00", 32'(dif.forwarda_d_0), 32'd0);
    step("fwd.b");

    // Two memory ops split; redirect in SLOT1 releases slot 1.
    clear_inputs();
    dif.valid_d = 1'b1; dif.memop_d_0 = 1'b1; dif.memop_d_1 = 1'b1;
    step("memop.split");
    dif.redirect_d = 1'b1;
    step("memop.redirect");
    check("memop.back_to_pair", 32'(state_o), 32'(PAIR));

    // Reset while slot 1 is pending.
    dif.redirect_d = 1'b0;
    step("rst.split");
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    check_all("rst.mid_slot1");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random pairs with a small register window so hazards are common.
    for (int n = 0; n < 400; n++) begin
      dif.valid_d      = ($urandom_range(0, 7) != 0);
      dif.redirect_d   = ($urandom_range(0, 9) == 0);
      dif.rs_d_0       = 5'($urandom_range(0, 6));
      dif.rt_d_0       = 5'($urandom_range(0, 6));
      dif.dst_d_0      = 5'($urandom_range(0, 6));
      dif.rs_d_1       = 5'($urandom_range(0, 6));
      dif.rt_d_1       = 5'($urandom_range(0, 6));
      dif.dst_d_1      = 5'($urandom_range(0, 6));
      dif.regwrite_d_0 = 1'($urandom);
      dif.regwrite_d_1 = 1'($urandom);
      dif.memop_d_0    = ($urandom_range(0, 2) == 0);
      dif.memop_d_1    = ($urandom_range(0, 2) == 0);
      dif.ctrl_d_0     = ($urandom_range(0, 3) == 0);
      dif.ctrl_d_1     = ($urandom_range(0, 5) == 0);
      dif.dst_e_0      = 5'($urandom_range(0, 6));
      dif.dst_e_1      = 5'($urandom_range(0, 6));
      dif.memread_e_0  = ($urandom_range(0, 2) == 0);
      dif.memread_e_1  = ($urandom_range(0, 2) == 0);
      dif.regwrite_e_0 = 1'($urandom);
      dif.regwrite_e_1 = 1'($urandom);
      dif.writeReg_m_0 = 5'($urandom_range(0, 6));
      dif.writeReg_m_1 = 5'($urandom_range(0, 6));
      dif.regWrite_m_0 = 1'($urandom);
      dif.regWrite_m_1 = 1'($urandom);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
